// File: rtl/rotary_debounce.sv
// Two-channel quadrature encoder debouncer: 2-flop synchronizer plus a stability counter per channel.
// Optional illegal-Gray-step detection is compiled in with `define ROTARY_DEB_ERR_EN.
module rotary_debounce #(
    parameter int DEB_CYCLES = 4,
    parameter int CNTW       = 16
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_enc_a,
    input  logic i_enc_b,
    input  logic i_err_clr,
    output logic o_enc_a,
    output logic o_enc_b,
    output logic o_chg,
    output logic o_err
);

    localparam logic [CNTW-1:0] CNT_MAX = CNTW'(DEB_CYCLES - 1);

    // Bit 0 is channel A, bit 1 is channel B throughout.
    logic [1:0]      raw;
    logic [1:0]      s1;
    logic [1:0]      s2;
    logic [1:0]      deb;
    logic [1:0]      upd;
    logic [CNTW-1:0] cnt [2];
    logic            chg_q;

    assign raw = {i_enc_b, i_enc_a};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1 <= 2'b00;
            s2 <= 2'b00;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    // An output flips only when the synchronized level has differed from it for DEB_CYCLES edges.
    always_comb begin
        upd = 2'b00;
        for (int i = 0; i < 2; i++) begin
            upd[i] = (s2[i] != deb[i]) && (cnt[i] == CNT_MAX);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            deb   <= 2'b00;
            chg_q <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            chg_q <= |upd;
            for (int i = 0; i < 2; i++) begin
                if (s2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    deb[i] <= s2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign o_enc_a = deb[0];
    assign o_enc_b = deb[1];
    assign o_chg   = chg_q;

`ifdef ROTARY_DEB_ERR_EN
    logic both_q;
    logic err_q;

    // The flag lands one cycle after the double update; a set in that cycle beats a clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            both_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            both_q <= &upd;
            if (both_q) begin
                err_q <= 1'b1;
            end else if (i_err_clr) begin
                err_q <= 1'b0;
            end
        end
    end

    assign o_err = err_q;
`else
    logic unused_err_clr;

    assign unused_err_clr = i_err_clr;
    assign o_err          = 1'b0;
`endif

endmodule

// File: tb/tb_rotary_debounce.sv
// Bench for rotary_debounce: DEB_CYCLES=4 and DEB_CYCLES=1 instances driven in parallel and
// compared every cycle against a window-based model of the debounce rule.
module tb_rotary_debounce;

    localparam int NI = 2;
`ifdef ROTARY_DEB_ERR_EN
    localparam bit ERR_EXP = 1'b1;
`else
    localparam bit ERR_EXP = 1'b0;
`endif

    logic i_clk = 1'b0;
    logic i_rst_n = 1'b0;
    logic i_enc_a = 1'b0;
    logic i_enc_b = 1'b0;
    logic i_err_clr = 1'b0;
    logic o_enc_a, o_enc_b, o_chg, o_err;
    logic o1_enc_a, o1_enc_b, o1_chg, o1_err;

    int checks = 0;
    int passes = 0;
    int fails = 0;

    rotary_debounce #(.DEB_CYCLES(4), .CNTW(16)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_enc_a(i_enc_a), .i_enc_b(i_enc_b),
        .i_err_clr(i_err_clr), .o_enc_a(o_enc_a), .o_enc_b(o_enc_b), .o_chg(o_chg), .o_err(o_err)
    );

    rotary_debounce #(.DEB_CYCLES(1), .CNTW(4)) dut1 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_enc_a(i_enc_a), .i_enc_b(i_enc_b),
        .i_err_clr(i_err_clr), .o_enc_a(o1_enc_a), .o_enc_b(o1_enc_b), .o_chg(o1_chg), .o_err(o1_err)
    );

    always #5 i_clk = ~i_clk;

    // Reference model: pin samples per edge; an output takes a new value when the samples that
    // reached the second synchronizer stage over the last DEB edges all hold that new value.
    int deb_of [NI] = '{4, 1};
    bit pa[$];
    bit pb[$];
    bit m_a [NI];
    bit m_b [NI];
    bit m_chg [NI];
    bit m_err [NI];
    bit m_pend [NI];
    int chg_seen;

    function automatic bit settled(input bit q[$], input int deb, input bit v);
        for (int k = 0; k < deb; k++) begin
            if (q[q.size() - 3 - k] != v) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic m_reset();
        pa.delete();
        pb.delete();
        for (int k = 0; k < 8; k++) begin
            pa.push_back(1'b0);
            pb.push_back(1'b0);
        end
        for (int i = 0; i < NI; i++) begin
            m_a[i] = 0; m_b[i] = 0; m_chg[i] = 0; m_err[i] = 0; m_pend[i] = 0;
        end
    endtask

    task automatic m_edge(input bit a, input bit b, input bit clr);
        bit ua, ub;
        pa.push_back(a);
        pb.push_back(b);
        for (int i = 0; i < NI; i++) begin
            ua = settled(pa, deb_of[i], !m_a[i]);
            ub = settled(pb, deb_of[i], !m_b[i]);
            if (ERR_EXP) begin
                if (m_pend[i]) m_err[i] = 1'b1;
                else if (clr) m_err[i] = 1'b0;
            end else begin
                m_err[i] = 1'b0;
            end
            m_pend[i] = ua && ub;
            m_a[i]    = m_a[i] ^ ua;
            m_b[i]    = m_b[i] ^ ub;
            m_chg[i]  = ua || ub;
        end
        while (pa.size() > 10) void'(pa.pop_front());
        while (pb.size() > 10) void'(pb.pop_front());
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string where);
        chk({where, " enc_a"}, 32'(o_enc_a), 32'(m_a[0]));
        chk({where, " enc_b"}, 32'(o_enc_b), 32'(m_b[0]));
        chk({where, " chg"}, 32'(o_chg), 32'(m_chg[0]));
        chk({where, " err"}, 32'(o_err), 32'(m_err[0]));
        chk({where, " d1 enc_a"}, 32'(o1_enc_a), 32'(m_a[1]));
        chk({where, " d1 enc_b"}, 32'(o1_enc_b), 32'(m_b[1]));
        chk({where, " d1 chg"}, 32'(o1_chg), 32'(m_chg[1]));
        chk({where, " d1 err"}, 32'(o1_err), 32'(m_err[1]));
    endtask

    task automatic step();
        bit a, b, clr;
        a = i_enc_a; b = i_enc_b; clr = i_err_clr;
        @(posedge i_clk);
        m_edge(a, b, clr);
        #1;
        if (o_chg === 1'b1) chg_seen++;
        chk_all("cycle");
    endtask

    // Runs n edges and reports the first edge index at which each output of dut reads 1.
    task automatic watch(input int n, output int rise_a, output int rise_b);
        rise_a = 0;
        rise_b = 0;
        for (int i = 1; i <= n; i++) begin
            step();
            if (o_enc_a === 1'b1 && rise_a == 0) rise_a = i;
            if (o_enc_b === 1'b1 && rise_b == 0) rise_b = i;
        end
    endtask

    initial begin
        int ra, rb, ha, hb;
        m_reset();
        repeat (2) @(posedge i_clk);
        #1;
        chk_all("in_reset");
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // Single rising edge on A.
        i_enc_a = 1'b1;
        chg_seen = 0;
        watch(10, ra, rb);
        chk("a_rise_edge", 32'(ra), 32'd6);
        chk("a_rise_chg_count", 32'(chg_seen), 32'd1);
        chk("a_rise_b_quiet", 32'(rb), 32'd0);

        // Return A low, then a 3-cycle high glitch must be rejected.
        i_enc_a = 1'b0;
        repeat (8) step();
        chk("a_low_again", 32'(o_enc_a), 32'd0);
        chg_seen = 0;
        i_enc_a = 1'b1;
        repeat (3) step();
        i_enc_a = 1'b0;
        repeat (10) step();
        chk("glitch_chg_count", 32'(chg_seen), 32'd0);
        chk("glitch_a_low", 32'(o_enc_a), 32'd0);

        // Bounce every 2 cycles, then settle high.
        chg_seen = 0;
        for (int i = 0; i < 40; i++) begin
            i_enc_a = ((i / 2) % 2 == 0);
            step();
        end
        i_enc_a = 1'b1;
        watch(10, ra, rb);
        chk("bounce_rise_edge", 32'(ra), 32'd6);
        chk("bounce_chg_count", 32'(chg_seen), 32'd1);

        // Both channels rise together: illegal step.
        i_enc_a = 1'b0;
        i_enc_b = 1'b0;
        repeat (10) step();
        chg_seen = 0;
        i_enc_a = 1'b1;
        i_enc_b = 1'b1;
        watch(6, ra, rb);
        chk("both_rise_a", 32'(ra), 32'd6);
        chk("both_rise_b", 32'(rb), 32'd6);
        chk("both_chg_count", 32'(chg_seen), 32'd1);
        step();
        chk("both_err_next", 32'(o_err), 32'(ERR_EXP));
        i_err_clr = 1'b1;
        step();
        i_err_clr = 1'b0;
        step();
        chk("err_cleared", 32'(o_err), 32'd0);

        // Quadrature cycle 00 -> 10 -> 11 -> 01 -> 00 (written as A,B).
        i_enc_a = 1'b0;
        i_enc_b = 1'b0;
        repeat (10) step();
        chg_seen = 0;
        for (int s = 0; s < 4; s++) begin
            i_enc_a = (s == 0 || s == 1);
            i_enc_b = (s == 1 || s == 2);
            repeat (10) step();
        end
        repeat (6) step();
        chk("quad_chg_count", 32'(chg_seen), 32'd4);
        chk("quad_err", 32'(o_err), 32'd0);

        // Asynchronous reset between edges while B is mid-count.
        i_enc_a = 1'b1;
        repeat (8) step();
        i_enc_b = 1'b1;
        repeat (2) step();
        #3;
        i_rst_n = 1'b0;
        #1;
        m_reset();
        chk_all("async_reset");
        i_enc_a = 1'b0;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        watch(10, ra, rb);
        chk("post_reset_b_rise", 32'(rb), 32'd6);
        chk("post_reset_a_quiet", 32'(ra), 32'd0);

        // Random independent hold times per channel with occasional error clears.
        ha = 1;
        hb = 1;
        for (int i = 0; i < 500; i++) begin
            ha--;
            hb--;
            if (ha == 0) begin
                i_enc_a = !i_enc_a;
                ha = $urandom_range(1, 9);
            end
            if (hb == 0) begin
                i_enc_b = !i_enc_b;
                hb = $urandom_range(1, 9);
            end
            i_err_clr = ($urandom_range(0, 15) == 0);
            step();
        end
        i_err_clr = 1'b0;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/rotary_debounce.md
ROTARY_DEBOUNCE -- requirements
Module: rotary_debounce

Interface
REQ-001 The block SHALL have parameter DEB_CYCLES, default 4, meaning the consecutive stable clock cycles required before a debounced output changes (legal range 1..65535).
REQ-002 The block SHALL have parameter CNTW, default 16, meaning the stability counter width; CNTW SHALL be wide enough to hold DEB_CYCLES-1.
REQ-003 i_clk  input  1  single clock; all state on rising edge.
REQ-004 i_rst_n  input  1  asynchronous active-low reset.
REQ-005 i_enc_a  input  1  raw encoder channel A, asynchronous to i_clk.
REQ-006 i_enc_b  input  1  raw encoder channel B, asynchronous to i_clk.
REQ-007 i_err_clr  input  1  synchronous clear of the sticky error flag.
REQ-008 o_enc_a  output  1  debounced channel A, feeds the quadrature decoder's A input.
REQ-009 o_enc_b  output  1  debounced channel B, feeds the quadrature decoder's B input.
REQ-010 o_chg  output  1  one-cycle pulse, high in the first cycle a new o_enc_a/o_enc_b value is visible.
REQ-011 o_err  output  1  sticky flag: both debounced channels changed in the same cycle (illegal Gray step).

Function
REQ-012 Each channel SHALL pass through a two-flop synchronizer (s1, s2); s2 is the only value used downstream.
REQ-013 Each channel SHALL have an independent counter cnt: if s2 == output, cnt <= 0; else if cnt == DEB_CYCLES-1, output <= s2 and cnt <= 0; else cnt <= cnt+1.
REQ-014 A level change held stable at the pin SHALL appear at the debounced output exactly 2+DEB_CYCLES clock edges after the first edge that samples it.
REQ-015 Any pin deviation shorter than DEB_CYCLES cycles (after synchronization) SHALL be rejected with no output change, no o_chg and the counter returned to 0.
REQ-016 With DEB_CYCLES == 1 the outputs SHALL follow s2 with one cycle of delay and no filtering.
REQ-017 o_chg SHALL be registered and asserted for exactly one cycle, in the same cycle the updated output appears; simultaneous A and B updates SHALL produce a single o_chg pulse.
REQ-018 The counter SHALL never exceed DEB_CYCLES-1 and SHALL never wrap.
REQ-019 A and B SHALL be filtered fully independently; activity on one channel SHALL not alter the other's counter.

Reset
REQ-020 Assertion of i_rst_n low SHALL immediately clear s1, s2, cnt, o_enc_a, o_enc_b, o_chg and o_err to 0, regardless of clock.
REQ-021 Reset asserted mid-count SHALL discard the pending transition; after release filtering restarts from zero state.
REQ-022 Reset deassertion SHALL be synchronized externally; outputs stay 0 until a pin high is stable 2+DEB_CYCLES cycles after release.

Configuration
REQ-023 Macro ROTARY_DEB_ERR_EN SHALL control illegal-step detection.
REQ-024 With ROTARY_DEB_ERR_EN defined, o_err SHALL set on the cycle after both outputs update together, hold until i_err_clr is sampled high, and set SHALL win over a simultaneous clear.
REQ-025 Without ROTARY_DEB_ERR_EN, o_err SHALL be constant 0, i_err_clr SHALL be ignored and no error logic SHALL be synthesized.

Verification (DEB_CYCLES = 4)
REQ-026 Reset then i_enc_a 0->1 held -> o_enc_a rises exactly 6 edges later, o_chg high that same cycle only, o_enc_b stays 0.
REQ-027 i_enc_a 3-cycle high pulse, then 0 -> o_enc_a stays 0, o_chg never asserts, cnt returns to 0.
REQ-028 i_enc_a toggling every 2 cycles for 40 cycles then held 1 -> single o_enc_a rise 6 edges after final settle, one o_chg pulse.
REQ-029 i_enc_a and i_enc_b both 0->1 on the same edge -> both outputs rise same cycle, one o_chg pulse, o_err = 1 next cycle (macro on) / 0 (macro off); i_err_clr pulse -> o_err = 0.
REQ-030 i_enc_b high for 2 cycles when reset asserted asynchronously between edges -> all outputs 0 at once; after release with pin held high, o_enc_b rises 6 edges later.
REQ-031 Quadrature sequence AB 00->10->11->01->00, each step held 10 cycles -> outputs reproduce the sequence delayed 6 cycles, four o_chg pulses, o_err stays 0.
